sig_dump_ctrl: RTL and testbench

//  Synthesizable end-of-test monitor that sits downstream of the SOC data-store bus.

---
 rtl/sig_dump_ctrl.sv | 131 +++++++++++++
 tb/tb_sig_dump_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sig_dump_ctrl.sv
// End-of-test monitor: snoops the mailbox stores, freezes the core on halt and streams
// the signature range [begin,end) out over a valid/ready port, one word per read.
module sig_dump_ctrl #(
  parameter logic [31:0] MBOX_BASE = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             st_en,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  output logic             core_halt,
  output logic             rd_req,
  output logic [31:0]      rd_addr,
  input  logic [31:0]      rd_data,
  output logic             sig_valid,
  output logic [31:0]      sig_data,
  input  logic             sig_ready,
  output logic [CNT_W-1:0] sig_cnt,
  output logic             done,
  output logic             error
);

  localparam logic [31:0] BegAddr  = MBOX_BASE + 32'd8;
  localparam logic [31:0] EndAddr  = MBOX_BASE + 32'd12;
  localparam logic [31:0] HaltAddr = MBOX_BASE + 32'd16;

  typedef enum logic [2:0] {
    StSnoop,
    StCheck,
    StRead,
    StWait,
    StEmit,
    StDone,
    StErr
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      beg_q, beg_d;
  logic [31:0]      end_q, end_d;
  logic [31:0]      ptr_q, ptr_d;
  logic [31:0]      dat_q, dat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] span;
  logic [31:0] ptr_nxt;
  logic        range_bad;

  assign span    = end_q - beg_q;
  assign ptr_nxt = ptr_q + 32'd4;
  // span is only meaningful when end >= begin; the ordering test covers the other case
  assign range_bad = (beg_q[1:0] != 2'b00) || (end_q[1:0] != 2'b00) || (end_q < beg_q) ||
                     ((span >> 2) > 32'(MAX_WORDS));

  always_comb begin
    state_d = state_q;
    beg_d   = beg_q;
    end_d   = end_q;
    ptr_d   = ptr_q;
    dat_d   = dat_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StSnoop: begin
        if (st_en) begin
          if (st_addr == BegAddr) begin
            beg_d = st_data;
          end else if (st_addr == EndAddr) begin
            end_d = st_data;
          end else if (st_addr == HaltAddr && st_data == 32'h1) begin
            state_d = StCheck;
          end
        end
      end
      StCheck: begin
        if (range_bad) begin
          state_d = StErr;
        end else if (end_q == beg_q) begin
          state_d = StDone;
        end else begin
          ptr_d   = beg_q;
          state_d = StRead;
        end
      end
      StRead: state_d = StWait;
      StWait: begin
        dat_d   = rd_data;
        state_d = StEmit;
      end
      StEmit: begin
        if (sig_ready) begin
          cnt_d   = cnt_q + CNT_W'(1);
          ptr_d   = ptr_nxt;
          state_d = (ptr_nxt == end_q) ? StDone : StRead;
        end
      end
      StDone:  state_d = StDone;
      StErr:   state_d = StErr;
      default: state_d = StSnoop;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StSnoop;
      beg_q   <= '0;
      end_q   <= '0;
      ptr_q   <= '0;
      dat_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      beg_q   <= beg_d;
      end_q   <= end_d;
      ptr_q   <= ptr_d;
      dat_q   <= dat_d;
      cnt_q   <= cnt_d;
    end
  end

  // Halt is held by every post-snoop state, so it follows the state register directly.
  assign core_halt = (state_q != StSnoop);
  assign rd_req    = (state_q == StRead);
  assign rd_addr   = rd_req ? ptr_q : 32'h0;
  assign sig_valid = (state_q == StEmit);
  assign sig_data  = sig_valid ? dat_q : 32'h0;
  assign sig_cnt   = cnt_q;
  assign done      = (state_q == StDone);
  assign error     = (state_q == StErr);

endmodule

// File: tb/tb_sig_dump_ctrl.sv
// Scoreboard bench for sig_dump_ctrl: directed mailbox sequences push expected reads and
// signature words; a negedge monitor pops and compares as the DUT presents them.
module tb_sig_dump_ctrl;

  localparam logic [31:0] MBOX      = 32'h0000_0000;
  localparam int unsigned MAX_WORDS = 1024;
  localparam int unsigned CNT_W     = 16;

  logic             clk;
  logic             rstn;
  logic             st_en;
  logic [31:0]      st_addr;
  logic [31:0]      st_data;
  logic             core_halt;
  logic             rd_req;
  logic [31:0]      rd_addr;
  logic [31:0]      rd_data;
  logic             sig_valid;
  logic [31:0]      sig_data;
  logic             sig_ready;
  logic [CNT_W-1:0] sig_cnt;
  logic             done;
  logic             error;

  sig_dump_ctrl #(
    .MBOX_BASE(MBOX),
    .MAX_WORDS(MAX_WORDS),
    .CNT_W    (CNT_W)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .st_en    (st_en),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .core_halt(core_halt),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .sig_valid(sig_valid),
    .sig_data (sig_data),
    .sig_ready(sig_ready),
    .sig_cnt  (sig_cnt),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  // Small RAM model; read data appears exactly one cycle after the request.
  logic [31:0] mem [256];
  always @(posedge clk) rd_data <= rd_req ? mem[rd_addr[9:2]] : 32'h0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %h, expected nothing", name, act);
  endtask

  // Monitor
  logic        stall_q;
  logic [31:0] stall_data_q;
  always @(negedge clk) begin
    if (!rstn) begin
      stall_q <= 1'b0;
    end else begin
      if (stall_q) begin
        check("hold_valid", {31'h0, sig_valid}, 32'h1);
        check("hold_data", sig_data, stall_data_q);
      end
      if (rd_req) begin
        if (exp_addr_q.size() == 0) fail_now("rd_addr_unexpected", rd_addr);
        else check("rd_addr", rd_addr, exp_addr_q.pop_front());
      end else begin
        check("rd_addr_idle", rd_addr, 32'h0);
      end
      if (sig_valid && sig_ready) begin
        if (exp_data_q.size() == 0) fail_now("sig_data_unexpected", sig_data);
        else check("sig_data", sig_data, exp_data_q.pop_front());
      end
      if (!sig_valid) check("sig_data_idle", sig_data, 32'h0);
      stall_q      <= sig_valid && !sig_ready;
      stall_data_q <= sig_data;
    end
  end

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    st_en   = 1'b1;
    st_addr = addr;
    st_data = data;
    @(posedge clk);
    #1;
    st_en   = 1'b0;
    st_addr = 32'h0;
    st_data = 32'h0;
  endtask

  task automatic do_reset(input bit check_outs);
    rstn      = 1'b0;
    st_en     = 1'b0;
    sig_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    if (check_outs) begin
      check("rst_outs", {core_halt, rd_req, sig_valid, done, error}, 32'h0);
      check("rst_rd_addr", rd_addr, 32'h0);
      check("rst_sig_data", sig_data, 32'h0);
      check("rst_sig_cnt", 32'(sig_cnt), 32'h0);
    end
    exp_addr_q.delete();
    exp_data_q.delete();
    rstn = 1'b1;
  endtask

  task automatic run_dump(input logic [31:0] beg, input logic [31:0] fin, input bit toggle,
                          input bit exp_err, input int exp_cnt);
    bit finished;
    sig_ready = !toggle;
    store(MBOX + 32'd8, beg);
    store(MBOX + 32'd12, fin);
    if (!exp_err) begin
      for (logic [31:0] a = beg; a < fin; a += 32'd4) begin
        exp_addr_q.push_back(a);
        exp_data_q.push_back(mem[a[9:2]]);
      end
    end
    store(MBOX + 32'd16, 32'h1);
    check("halt_within_1", {31'h0, core_halt}, 32'h1);
    finished = 1'b0;
    for (int i = 0; i < 300 && !finished; i++) begin
      @(posedge clk);
      #1;
      if (toggle) sig_ready = ~sig_ready;
      finished = done || error;
    end
    if (!finished) fail_now("dump_timeout", {30'h0, done, error});
    check("done", {31'h0, done}, {31'h0, !exp_err});
    check("error", {31'h0, error}, {31'h0, exp_err});
    check("sig_cnt", 32'(sig_cnt), 32'(exp_cnt));
    check("halt_held", {31'h0, core_halt}, 32'h1);
    check("addr_q_left", 32'(exp_addr_q.size()), 32'h0);
    check("data_q_left", 32'(exp_data_q.size()), 32'h0);
  endtask

  initial begin
    bit hit;
    clk       = 1'b0;
    rstn      = 1'b0;
    st_en     = 1'b0;
    st_addr   = 32'h0;
    st_data   = 32'h0;
    sig_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h5A5A_0000 | 32'(i);
    mem[8'h40] = 32'hCAFE_0001;
    mem[8'h41] = 32'hBEEF_0002;
    mem[8'h42] = 32'h1234_5678;

    // T1 + T2
    do_reset(1'b1);
    run_dump(32'h100, 32'h10C, 1'b0, 1'b0, 3);

    // T3 backpressure
    do_reset(1'b0);
    run_dump(32'h100, 32'h10C, 1'b1, 1'b0, 3);

    // T4 bad ranges
    do_reset(1'b0);
    run_dump(32'h110, 32'h100, 1'b0, 1'b1, 0);
    do_reset(1'b0);
    run_dump(32'h102, 32'h10C, 1'b0, 1'b1, 0);
    do_reset(1'b0);
    run_dump(32'h1000, 32'h1000 + 32'(4 * (MAX_WORDS + 1)), 1'b0, 1'b1, 0);

    // T5 empty range, then halt with wrong data
    do_reset(1'b0);
    run_dump(32'h200, 32'h200, 1'b0, 1'b0, 0);
    do_reset(1'b0);
    store(MBOX + 32'd8, 32'h100);
    store(MBOX + 32'd12, 32'h10C);
    store(MBOX + 32'd16, 32'h2);
    repeat (4) @(posedge clk);
    #1;
    check("bad_halt_outs", {core_halt, rd_req, sig_valid, done, error}, 32'h0);

    // T6 reset while word 2 is waiting in EMIT
    do_reset(1'b0);
    sig_ready = 1'b1;
    store(MBOX + 32'd8, 32'h100);
    store(MBOX + 32'd12, 32'h10C);
    for (int k = 0; k < 3; k++) begin
      exp_addr_q.push_back(32'h100 + 32'(4 * k));
      exp_data_q.push_back(mem[8'h40 + k]);
    end
    store(MBOX + 32'd16, 32'h1);
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(posedge clk);
      #1;
      hit = (sig_cnt == CNT_W'(1));
    end
    sig_ready = 1'b0;
    if (!hit) fail_now("t6_first_word_timeout", 32'(sig_cnt));
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(posedge clk);
      #1;
      hit = sig_valid;
    end
    if (!hit) fail_now("t6_emit_timeout", 32'(sig_cnt));
    check("t6_emit_data", sig_data, 32'hBEEF_0002);
    rstn = 1'b0;
    #1;
    check("t6_rst_outs", {core_halt, rd_req, sig_valid, done, error}, 32'h0);
    check("t6_rst_data", sig_data, 32'h0);
    check("t6_rst_cnt", 32'(sig_cnt), 32'h0);
    check("t6_unsent_words", 32'(exp_data_q.size()), 32'h2);
    do_reset(1'b0);
    run_dump(32'h100, 32'h10C, 1'b0, 1'b0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
